// File: rtl/tile_bus_arbiter.sv
// tile_bus_arbiter
// Round-robin arbiter that lets NUM_PORTS L1 clients share one master bus.
// One transaction is in flight at a time. The winner's address, data, byte
// enables and write enable are latched at grant and held on m_* until the
// transaction completes.
//
// Optional feature (macro TILE_ARB_TIMEOUT_EN): a bus-wait watchdog. When a
// BUSY period reaches TIMEOUT_CYCLES cycles without m_ready, the transaction
// ends with p_ready and p_err pulsing together. When the macro is undefined,
// BUSY waits for m_ready with no limit and p_err is tied to 0.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   p_addr/p_wdata/p_be     per-port payload; port i occupies slice i
//   p_we, p_req             per-port write enable and request level
//   p_rdata                 read data shared by all ports, 0 unless p_ready
//   p_ready, p_err          one-hot completion / timeout-error pulses
//   m_addr/m_wdata/m_be/m_we/m_req   master-side request
//   m_rdata, m_ready        master-side response
//   owner                   index of the current or last granted port
//
// state | meaning
// IDLE  | no transaction in flight; arbitrate among p_req
// BUSY  | m_req high; waiting for m_ready (or watchdog expiry)

module tile_bus_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int BE_WIDTH      = DATA_WIDTH / 8,
    localparam int OW            = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] p_wdata,
    input  logic [NUM_PORTS*BE_WIDTH-1:0]   p_be,
    input  logic [NUM_PORTS-1:0]            p_we,
    input  logic [NUM_PORTS-1:0]            p_req,
    output logic [DATA_WIDTH-1:0]           p_rdata,
    output logic [NUM_PORTS-1:0]            p_ready,
    output logic [NUM_PORTS-1:0]            p_err,
    output logic [ADDR_WIDTH-1:0]           m_addr,
    output logic [DATA_WIDTH-1:0]           m_wdata,
    output logic [BE_WIDTH-1:0]             m_be,
    output logic                            m_we,
    output logic                            m_req,
    input  logic [DATA_WIDTH-1:0]           m_rdata,
    input  logic                            m_ready,
    output logic [OW-1:0]                   owner
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [OW-1:0]           r_owner;
    logic [OW-1:0]           r_last_owner;
    logic [ADDR_WIDTH-1:0]   r_m_addr;
    logic [DATA_WIDTH-1:0]   r_m_wdata;
    logic [BE_WIDTH-1:0]     r_m_be;
    logic                    r_m_we;

    logic                    w_found;
    logic [OW-1:0]           w_grant_idx;
    logic                    w_grant;
    logic                    w_timeout;
    logic                    w_done;
    logic [NUM_PORTS-1:0]    w_owner_onehot;

    // Round-robin search starting just after the last owner, with wrap.
    always_comb begin : rr_search
        int            v_idx;
        logic [OW-1:0] v_cand;
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            v_idx  = (int'(r_last_owner) + i) % NUM_PORTS;
            v_cand = OW'(v_idx);
            if (!w_found && p_req[v_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = v_cand;
            end
        end
    end

    assign w_grant = (r_state == IDLE) && w_found;

`ifdef TILE_ARB_TIMEOUT_EN
    logic [15:0] r_wdog_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
        end else if (w_grant) begin
            r_wdog_cnt <= '0;
        end else if (r_state == BUSY && !m_ready) begin
            r_wdog_cnt <= r_wdog_cnt + 16'd1;
        end
    end

    // m_ready in the terminal cycle wins: that is a normal completion.
    assign w_timeout = (r_state == BUSY) && !m_ready &&
                       (r_wdog_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_done = (r_state == BUSY) && (m_ready || w_timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_found) w_state_nxt = BUSY;
            BUSY: if (w_done)  w_state_nxt = IDLE;
            default:           w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= '0;
            r_last_owner <= OW'(NUM_PORTS - 1);
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_m_be       <= '0;
            r_m_we       <= 1'b0;
        end else if (w_grant) begin
            r_owner      <= w_grant_idx;
            r_last_owner <= w_grant_idx;
            r_m_addr     <= p_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_m_wdata    <= p_wdata[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
            r_m_be       <= p_be[w_grant_idx*BE_WIDTH +: BE_WIDTH];
            r_m_we       <= p_we[w_grant_idx];
        end
    end

    assign w_owner_onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_owner;

    assign m_req   = (r_state == BUSY);
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_be    = r_m_be;
    assign m_we    = r_m_we;
    assign owner   = r_owner;

    assign p_ready = w_done ? w_owner_onehot : '0;
    assign p_err   = (w_timeout) ? w_owner_onehot : '0;
    assign p_rdata = (r_state == BUSY && m_ready) ? m_rdata : '0;

endmodule

// File: tb/tb_tile_bus_arbiter.sv
// Directed testbench for tile_bus_arbiter (NUM_PORTS=4, TIMEOUT_CYCLES=4).
// Inputs are driven 1 ns after the rising edge; outputs are sampled a further
// 1 ns later, well clear of the next edge.

module tb_tile_bus_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic            clk;
    logic            rst_n;
    logic [NP*AW-1:0] p_addr;
    logic [NP*DW-1:0] p_wdata;
    logic [NP*BW-1:0] p_be;
    logic [NP-1:0]   p_we;
    logic [NP-1:0]   p_req;
    logic [DW-1:0]   p_rdata;
    logic [NP-1:0]   p_ready;
    logic [NP-1:0]   p_err;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [BW-1:0]   m_be;
    logic            m_we;
    logic            m_req;
    logic [DW-1:0]   m_rdata;
    logic            m_ready;
    logic [1:0]      owner;

    int n_checks = 0;
    int n_fail   = 0;

    tile_bus_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .p_addr(p_addr), .p_wdata(p_wdata), .p_be(p_be), .p_we(p_we),
        .p_req(p_req), .p_rdata(p_rdata), .p_ready(p_ready), .p_err(p_err),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_we(m_we),
        .m_req(m_req), .m_rdata(m_rdata), .m_ready(m_ready), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        p_addr  = '0; p_wdata = '0; p_be = '0; p_we = '0; p_req = '0;
        m_rdata = '0; m_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        p_addr = '0; p_wdata = '0; p_be = '0; p_we = '0; p_req = '0;
        m_rdata = 32'hFFFF_FFFF; m_ready = 1'b1;
        tick(); #1;
        n_checks++;
        if (m_req !== 1'b0 || m_we !== 1'b0 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: m_req=%b m_we=%b owner=%0d, required 0 0 0", m_req, m_we, owner);
        end
        n_checks++;
        if (m_addr !== '0 || m_wdata !== '0 || m_be !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: m_addr=%h m_wdata=%h m_be=%h, required 0", m_addr, m_wdata, m_be);
        end
        n_checks++;
        if (p_ready !== '0 || p_err !== '0 || p_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_resp: p_ready=%b p_err=%b p_rdata=%h, required 0", p_ready, p_err, p_rdata);
        end
        apply_reset();
    endtask

    task automatic test_single_read();
        p_addr[1*AW +: AW] = 32'h0000_1000;
        p_we[1]  = 1'b0;
        p_req    = 4'b0010;
        tick();
        n_checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h1000 || owner !== 2'd1 || m_we !== 1'b0) begin
            n_fail++;
            $display("FAIL read_grant: m_req=%b m_addr=%h owner=%0d m_we=%b, required 1 00001000 1 0", m_req, m_addr, owner, m_we);
        end
        tick();
        n_checks++;
        if (m_req !== 1'b1 || p_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL read_wait: m_req=%b p_ready=%b, required 1 0000", m_req, p_ready);
        end
        tick();
        m_ready = 1'b1; m_rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (p_ready !== 4'b0010 || p_rdata !== 32'hDEAD_BEEF || p_err !== 4'b0000) begin
            n_fail++;
            $display("FAIL read_done: p_ready=%b p_rdata=%h p_err=%b, required 0010 deadbeef 0000", p_ready, p_rdata, p_err);
        end
        p_req = '0;
        tick();
        m_ready = 1'b0;
        #1;
        n_checks++;
        if (m_req !== 1'b0 || p_ready !== 4'b0000 || p_rdata !== '0) begin
            n_fail++;
            $display("FAIL read_after: m_req=%b p_ready=%b p_rdata=%h, required 0 0000 0", m_req, p_ready, p_rdata);
        end
    endtask

    task automatic test_write_hold();
        p_addr[0 +: AW]  = 32'h0000_0020;
        p_wdata[0 +: DW] = 32'h1234_5678;
        p_be[0 +: BW]    = 4'b0011;
        p_we[0]          = 1'b1;
        p_req            = 4'b0001;
        tick();
        n_checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h20 || m_wdata !== 32'h1234_5678 || m_be !== 4'b0011 || m_we !== 1'b1) begin
            n_fail++;
            $display("FAIL write_grant: m_req=%b m_addr=%h m_wdata=%h m_be=%b m_we=%b, required 1 20 12345678 0011 1",
                     m_req, m_addr, m_wdata, m_be, m_we);
        end
        p_wdata[0 +: DW] = '0;
        p_addr[0 +: AW]  = 32'hFFFF_0000;
        p_be[0 +: BW]    = 4'b1100;
        p_we[0]          = 1'b0;
        tick();
        tick();
        n_checks++;
        if (m_wdata !== 32'h1234_5678 || m_addr !== 32'h20 || m_be !== 4'b0011 || m_we !== 1'b1) begin
            n_fail++;
            $display("FAIL write_hold: m_wdata=%h m_addr=%h m_be=%b m_we=%b, required 12345678 20 0011 1", m_wdata, m_addr, m_be, m_we);
        end
        m_ready = 1'b1; m_rdata = 32'h0;
        #1;
        n_checks++;
        if (p_ready !== 4'b0001 || m_wdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL write_done: p_ready=%b m_wdata=%h, required 0001 12345678", p_ready, m_wdata);
        end
        p_req = '0;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_contention();
        int gap;
        apply_reset();
        for (int i = 0; i < NP; i++) p_addr[i*AW +: AW] = 32'(i * 32'h100);
        p_req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            gap = 0;
            tick();
            m_ready = 1'b0;
            while (m_req !== 1'b1 && gap < 8) begin
                gap++;
                tick();
            end
            n_checks++;
            if (gap != ((k == 0) ? 0 : 1)) begin
                n_fail++;
                $display("FAIL contention_gap[%0d]: idle cycles=%0d, required %0d", k, gap, (k == 0) ? 0 : 1);
                if (gap >= 8) begin
                    p_req = '0;
                    return;
                end
            end
            n_checks++;
            if (owner !== 2'(k % NP) || m_addr !== 32'((k % NP) * 32'h100)) begin
                n_fail++;
                $display("FAIL contention_owner[%0d]: owner=%0d m_addr=%h, required %0d %h", k, owner, m_addr, k % NP, (k % NP) * 32'h100);
            end
            tick();
            m_ready = 1'b1; m_rdata = 32'(32'hA000 + k);
            #1;
            n_checks++;
            if (p_ready !== (4'b0001 << (k % NP)) || p_rdata !== 32'(32'hA000 + k)) begin
                n_fail++;
                $display("FAIL contention_ready[%0d]: p_ready=%b p_rdata=%h, required %b %h", k, p_ready, p_rdata, 4'b0001 << (k % NP), 32'hA000 + k);
            end
        end
        p_req = '0;
        tick();
        m_ready = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int hi_cnt;
        m_rdata = 32'hCAFE_F00D;
        m_ready = 1'b0;
        p_req   = 4'b0001;
        tick();
`ifdef TILE_ARB_TIMEOUT_EN
        tick(); tick();
        n_checks++;
        if (m_req !== 1'b1 || p_ready !== 4'b0000 || p_err !== 4'b0000) begin
            n_fail++;
            $display("FAIL timeout_early: m_req=%b p_ready=%b p_err=%b, required 1 0000 0000", m_req, p_ready, p_err);
        end
        tick();
        n_checks++;
        if (p_ready !== 4'b0001 || p_err !== 4'b0001 || p_rdata !== '0) begin
            n_fail++;
            $display("FAIL timeout_pulse: p_ready=%b p_err=%b p_rdata=%h, required 0001 0001 0", p_ready, p_err, p_rdata);
        end
        p_req = '0;
        tick();
        n_checks++;
        if (m_req !== 1'b0 || p_err !== 4'b0000) begin
            n_fail++;
            $display("FAIL timeout_idle: m_req=%b p_err=%b, required 0 0000", m_req, p_err);
        end
        // m_ready in the terminal cycle is a normal completion
        p_req = 4'b0010;
        tick(); tick(); tick(); tick();
        m_ready = 1'b1;
        #1;
        n_checks++;
        if (p_ready !== 4'b0010 || p_err !== 4'b0000 || p_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL timeout_prio: p_ready=%b p_err=%b p_rdata=%h, required 0010 0000 cafef00d", p_ready, p_err, p_rdata);
        end
        p_req = '0;
        tick();
        m_ready = 1'b0;
`else
        hi_cnt = 0;
        for (int c = 0; c < 105; c++) begin
            if (m_req === 1'b1 && p_err === 4'b0000 && p_ready === 4'b0000) hi_cnt++;
            tick();
        end
        n_checks++;
        if (hi_cnt != 105) begin
            n_fail++;
            $display("FAIL no_timeout_hold: cycles with m_req high and no pulse=%0d, required 105", hi_cnt);
        end
        m_ready = 1'b1;
        #1;
        n_checks++;
        if (p_ready !== 4'b0001 || p_err !== 4'b0000 || p_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL no_timeout_done: p_ready=%b p_err=%b p_rdata=%h, required 0001 0000 cafef00d", p_ready, p_err, p_rdata);
        end
        p_req = '0;
        tick();
        m_ready = 1'b0;
`endif
        tick();
    endtask

    task automatic test_idle_ready();
        p_req   = '0;
        m_ready = 1'b1;
        m_rdata = 32'h5555_AAAA;
        #1;
        n_checks++;
        if (p_ready !== 4'b0000 || p_rdata !== '0 || p_err !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_ready: p_ready=%b p_rdata=%h p_err=%b, required 0000 0 0000", p_ready, p_rdata, p_err);
        end
        tick();
        n_checks++;
        if (m_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready_req: m_req=%b, required 0", m_req);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        p_addr[2*AW +: AW] = 32'h0000_0300;
        p_req = 4'b0100;
        tick();
        n_checks++;
        if (m_req !== 1'b1 || owner !== 2'd2) begin
            n_fail++;
            $display("FAIL rst_busy_pre: m_req=%b owner=%0d, required 1 2", m_req, owner);
        end
        #2;
        rst_n   = 1'b0;
        m_ready = 1'b1;
        m_rdata = 32'h1111_2222;
        #1;
        n_checks++;
        if (m_req !== 1'b0 || p_ready !== 4'b0000 || p_err !== 4'b0000 || p_rdata !== '0) begin
            n_fail++;
            $display("FAIL rst_busy_async: m_req=%b p_ready=%b p_err=%b p_rdata=%h, required 0 0000 0000 0", m_req, p_ready, p_err, p_rdata);
        end
        n_checks++;
        if (owner !== 2'd0 || m_addr !== '0) begin
            n_fail++;
            $display("FAIL rst_busy_regs: owner=%0d m_addr=%h, required 0 0", owner, m_addr);
        end
        tick(); tick();
        rst_n   = 1'b1;
        m_ready = 1'b0;
        p_addr[0 +: AW]  = 32'h0000_0A00;
        p_addr[1*AW +: AW] = 32'h0000_0B00;
        p_req = 4'b0011;
        tick();
        n_checks++;
        if (m_req !== 1'b1 || owner !== 2'd0 || m_addr !== 32'h0A00) begin
            n_fail++;
            $display("FAIL rst_tie: m_req=%b owner=%0d m_addr=%h, required 1 0 00000a00", m_req, owner, m_addr);
        end
        m_ready = 1'b1;
        #1;
        p_req = 4'b0010;
        tick();
        m_ready = 1'b0;
        tick();
        n_checks++;
        if (m_req !== 1'b1 || owner !== 2'd1) begin
            n_fail++;
            $display("FAIL rst_tie_next: m_req=%b owner=%0d, required 1 1", m_req, owner);
        end
        m_ready = 1'b1;
        #1;
        p_req = '0;
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_hold();
        test_contention();
        test_timeout();
        test_idle_ready();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_bus_arbiter.md
TILE_BUS_ARBITER -- requirements
Module: tile_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2 (legal 2..8), number of requesting L1 clients.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32 (multiple of 8), bus data width; BE_WIDTH = DATA_WIDTH/8.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256 (legal 2..65535), bus-wait watchdog limit.
REQ-005 SHALL have ports, in order:
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous, active-low reset
  p_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i in slice i
  p_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data
  p_be  in  NUM_PORTS*BE_WIDTH  per-port byte enables
  p_we  in  NUM_PORTS  per-port write enable
  p_req  in  NUM_PORTS  per-port request level
  p_rdata  out  DATA_WIDTH  read data, shared by all ports
  p_ready  out  NUM_PORTS  one-hot completion pulse
  p_err  out  NUM_PORTS  one-hot timeout-error pulse, coincident with p_ready
  m_addr  out  ADDR_WIDTH  master address
  m_wdata  out  DATA_WIDTH  master write data
  m_be  out  BE_WIDTH  master byte enables
  m_we  out  1  master write enable
  m_req  out  1  master request
  m_rdata  in  DATA_WIDTH  master read data
  m_ready  in  1  master completion
  owner  out  clog2(NUM_PORTS) (min 1)  index of current/last granted port

Function
REQ-006 SHALL implement FSM with states IDLE and BUSY.
REQ-007 In IDLE with any p_req set, SHALL select a winner round-robin, searching from (last_owner+1) mod NUM_PORTS upward with wrap-around, register its addr/wdata/be/we into m_* and owner, and enter BUSY at the next edge.
REQ-008 SHALL assert m_req exactly while in BUSY; first m_req cycle is one cycle after the winning p_req is first sampled in IDLE.
REQ-009 m_* SHALL hold the values latched at grant for the whole BUSY period, regardless of later port input changes.
REQ-010 In BUSY, the cycle m_ready=1: p_ready[owner]=1 (combinational from m_ready), p_rdata=m_rdata, all other p_ready bits 0; FSM returns to IDLE at the next edge.
REQ-011 p_rdata SHALL be 0 whenever no p_ready bit is asserted.
REQ-012 Clients SHALL hold p_req and payload until their p_ready; arbiter SHALL tolerate p_req deassertion only after p_ready (earlier withdrawal is unsupported, transaction still completes).
REQ-013 IDLE SHALL last at least one cycle between transactions (turnaround); back-to-back requests from the same port are granted only if no other port requests (round-robin fairness).
REQ-014 With all NUM_PORTS requesting continuously, each port SHALL be granted exactly once per NUM_PORTS transactions.
REQ-015 m_ready while in IDLE SHALL be ignored; no p_ready is generated.
REQ-016 Port 0 SHALL win the first arbitration after reset when multiple ports request (last_owner resets to NUM_PORTS-1).

Reset
REQ-017 rst_n low SHALL asynchronously force: state IDLE, m_req 0, m_we 0, m_addr/m_wdata/m_be 0, owner 0, last_owner NUM_PORTS-1, watchdog counter 0.
REQ-018 Reset asserted mid-BUSY SHALL abort the transaction with no p_ready/p_err pulse; p_ready, p_err, p_rdata are 0 during reset.

Configuration
REQ-019 Macro TILE_ARB_TIMEOUT_EN defined: a 16-bit counter clears on BUSY entry, increments each BUSY cycle without m_ready; on the BUSY cycle where the count equals TIMEOUT_CYCLES-1 and m_ready=0, SHALL pulse p_ready[owner] and p_err[owner] with p_rdata=0 and return to IDLE; m_ready in that same cycle takes priority (normal completion, no error).
REQ-020 Macro undefined: no counter is built, BUSY waits indefinitely for m_ready, p_err is constant 0.

Verification
REQ-021 Single read: port 1 req, addr 0x0000_1000, we 0; m_ready on 3rd m_req cycle with m_rdata 0xDEAD_BEEF -> m_addr 0x1000 on cycle 1, p_ready=2'b10 with p_rdata 0xDEADBEEF, m_req low next cycle.
REQ-022 Contention, NUM_PORTS=4, all ports request continuously, m_ready 1 cycle after each m_req -> owner sequence 0,1,2,3,0,1; each grant separated by one IDLE cycle.
REQ-023 Write hold: port 0 write addr 0x20, wdata 0x1234_5678, be 4'b0011; change p_wdata to 0 during BUSY -> m_wdata stays 0x12345678 until m_ready.
REQ-024 Timeout (macro on, TIMEOUT_CYCLES=4): m_ready never asserted -> p_ready[0] and p_err[0] pulse on 4th m_req cycle, p_rdata 0, FSM IDLE next cycle; macro off -> m_req stays high 100+ cycles, p_err 0.
REQ-025 Reset mid-BUSY: rst_n low for 2 cycles during m_req -> m_req drops immediately without clock edge, no p_ready; after release port 0 wins a 0/1 tie.
